half_subtractor_unit: RTL and testbench



---
 rtl/half_subtractor_unit.sv | 87 ++++++++
 tb/tb_half_subtractor_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/half_subtractor_unit.sv
// half_subtractor_unit
// Registered single-bit half subtractor: diff = a ^ b, borrow = ~a & b,
// presented one clock after the sampling edge together with out_valid.
// Optional saturating borrow-event counter, built only when the macro
// HALF_SUB_BORROW_CNT_EN is defined; otherwise borrow_count is tied to 0
// and cnt_clr is ignored.

module half_subtractor_unit #(
    parameter int unsigned CNT_W = 16   // borrow counter width, 1..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             cnt_clr,
    output logic             diff,
    output logic             borrow,
    output logic             out_valid,
    output logic [CNT_W-1:0] borrow_count
);

    logic w_diff;
    logic w_borrow;
    logic w_borrow_evt;

    logic r_diff;
    logic r_borrow;
    logic r_out_valid;

    // Bit-level subtract; only registered, never driven straight to a port.
    assign w_diff       = a ^ b;
    assign w_borrow     = ~a & b;
    assign w_borrow_evt = in_valid & w_borrow;

    // Result stage: capture on valid samples, hold otherwise; valid is one-shot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff      <= 1'b0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_diff   <= w_diff;
                r_borrow <= w_borrow;
            end
        end
    end

    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign out_valid = r_out_valid;

`ifdef HALF_SUB_BORROW_CNT_EN

    logic [CNT_W-1:0] r_borrow_count;
    logic             w_cnt_at_max;

    assign w_cnt_at_max = (r_borrow_count == {CNT_W{1'b1}});

    // Borrow-event counter: clear has priority, saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_borrow_count <= '0;
        end else if (cnt_clr) begin
            r_borrow_count <= '0;
        end else if (w_borrow_evt && !w_cnt_at_max) begin
            r_borrow_count <= r_borrow_count + 1'b1;
        end
    end

    assign borrow_count = r_borrow_count;

`else

    logic w_unused_cnt;

    // Counter not built: its inputs are intentionally left without a load.
    assign w_unused_cnt = cnt_clr | w_borrow_evt;
    assign borrow_count = '0;

`endif

endmodule

// File: tb/tb_half_subtractor_unit.sv
// Self-checking bench for half_subtractor_unit.
// Directed cases (reset, exhaustive truth table, hold, clear priority,
// saturation, mid-stream reset) followed by random stimulus, all compared
// against an arithmetic reference model. Honors HALF_SUB_BORROW_CNT_EN.

module tb_half_subtractor_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             a;
    logic             b;
    logic             cnt_clr;
    logic             diff;
    logic             borrow;
    logic             out_valid;
    logic [CNT_W-1:0] borrow_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_diff   = 0;
    int m_borrow = 0;
    int m_valid  = 0;
    int m_count  = 0;

    always #5 clk = ~clk;

    half_subtractor_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .cnt_clr      (cnt_clr),
        .diff         (diff),
        .borrow       (borrow),
        .out_valid    (out_valid),
        .borrow_count (borrow_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".diff"},      {31'd0, diff},              m_diff);
        check({tag, ".borrow"},    {31'd0, borrow},            m_borrow);
        check({tag, ".out_valid"}, {31'd0, out_valid},         m_valid);
        check({tag, ".count"},     {{(32-CNT_W){1'b0}}, borrow_count}, m_count);
    endtask

    // Model of one clock edge, from the arithmetic definition of a - b.
    task automatic model_edge(input int v, input int ai, input int bi, input int clr);
        if (v != 0) begin
            m_diff   = (ai - bi + 2) % 2;
            m_borrow = (ai < bi) ? 1 : 0;
        end
        m_valid = v;
`ifdef HALF_SUB_BORROW_CNT_EN
        if (clr != 0)
            m_count = 0;
        else if (v != 0 && ai < bi && m_count < CNT_MAX)
            m_count = m_count + 1;
`else
        m_count = 0;
`endif
    endtask

    task automatic model_reset();
        m_diff   = 0;
        m_borrow = 0;
        m_valid  = 0;
        m_count  = 0;
    endtask

    // Drive one sample at negedge, check outputs 1 ns after the next posedge.
    task automatic step(input string tag, input int v, input int ai, input int bi, input int clr);
        @(negedge clk);
        in_valid = v[0];
        a        = ai[0];
        b        = bi[0];
        cnt_clr  = clr[0];
        @(posedge clk);
        #1;
        model_edge(v, ai, bi, clr);
        check_all(tag);
    endtask

    initial begin
        // Reset asserted with active inputs: outputs must read zero.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 1'b1;
        b        = 1'b1;
        cnt_clr  = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Exhaustive truth table on successive cycles.
        step("tt00", 1, 0, 0, 0);
        step("tt01", 1, 0, 1, 0);
        step("tt10", 1, 1, 0, 0);
        step("tt11", 1, 1, 1, 0);

        // Hold: one borrow sample, then idle with a=b=1.
        step("hold_load", 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("hold", 0, 1, 1, 0);

        // Bring count to 5, then clear on the same edge as a borrow event.
        for (int i = 0; i < 3; i++) step("pre_clr", 1, 0, 1, 0);
        step("clr_prio", 1, 0, 1, 1);

        // Saturation: 20 consecutive borrow samples.
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 1, 0);
        step("sat_idle", 0, 0, 1, 0);

        // Random stimulus.
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 int'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15) == 0));
        end

        // Mid-stream reset: asserted between edges, outputs clear without a clock.
        step("pre_rst", 1, 0, 1, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step("post_rst_idle", 0, 1, 0, 0);
        step("post_rst_valid", 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
